// File: rtl/complex_exec_pipe_pkg.sv
// Shared types and constants for the complex-ALU latency-matching pipe.
package complex_exec_pipe_pkg;
  localparam int DATA_W     = 32;
  localparam int FLAGS_W    = 6;
  localparam int TAG_W      = 7;
  localparam int PIPE_DEPTH = 3;

  // flag field bit positions consumed by writeback
  localparam int FLG_EXECUTED   = 0;
  localparam int FLG_EXCEPTION  = 1;
  localparam int FLG_MISPREDICT = 2;
  localparam int FLG_OVERFLOW   = 3;
  localparam int FLG_DIV_ZERO   = 4;
  localparam int FLG_SYSCALL    = 5;

  typedef struct packed {
    logic [TAG_W-1:0]    tag;
    logic [2*DATA_W-1:0] result;
    logic [FLAGS_W-1:0]  flags;
  } payload_t;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/complex_exec_pipe_stage.sv
// One pipe stage: valid bit plus payload, loads whenever its slot opens.
module complex_pipe_stage
  import complex_exec_pipe_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     flush,
  input  logic     load,
  input  logic     in_v,
  input  payload_t in_p,
  output logic     v,
  output payload_t p
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      v <= 1'b0;
    else if (flush) v <= 1'b0;
    else if (load)  v <= in_v;
  end

  // payload only captures real data; empty-stage contents are don't-care
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                        p <= '0;
    else if (load && in_v && !flush)  p <= in_p;
  end
endmodule

// File: rtl/complex_exec_pipe.sv
// Latency-matching pipe between complex ALU and writeback with bubble collapsing.
module complex_exec_pipe
  import complex_exec_pipe_pkg::*;
#(
  parameter  int DEPTH = PIPE_DEPTH,
  localparam int CNT_W = cnt_w(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush_i,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic [TAG_W-1:0]    tag_i,
  input  logic [2*DATA_W-1:0] result_i,
  input  logic [FLAGS_W-1:0]  flags_i,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [TAG_W-1:0]    tag_o,
  output logic [2*DATA_W-1:0] result_o,
  output logic [FLAGS_W-1:0]  flags_o,
  output logic [CNT_W-1:0]    count_o
);
  logic [DEPTH-1:0] v, load;
  payload_t [DEPTH-1:0] p;
  logic accept, fire;

  assign valid_o = v[DEPTH-1] & ~flush_i;
  assign fire    = valid_o & ready_i;
  assign ready_o = load[0];
  assign accept  = valid_i & ready_o & ~flush_i;

  // a slot opens if it or any stage ahead of it is empty, or the head fires
  always_comb begin : ready_chain
    logic open;
    open = fire;
    load = '0;
    for (int k = DEPTH-1; k >= 0; k--) begin
      open    = open | ~v[k];
      load[k] = open;
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic     in_v;
    payload_t in_p;
    if (k == 0) begin : g_head_in
      assign in_v = accept;
      assign in_p = '{tag: tag_i, result: result_i, flags: flags_i};
    end else begin : g_chain_in
      assign in_v = v[k-1];
      assign in_p = p[k-1];
    end
    complex_pipe_stage u_stage (
      .clk   (clk),
      .reset (reset),
      .flush (flush_i),
      .load  (load[k]),
      .in_v  (in_v),
      .in_p  (in_p),
      .v     (v[k]),
      .p     (p[k])
    );
  end

  assign tag_o    = p[DEPTH-1].tag;
  assign result_o = p[DEPTH-1].result;
  assign flags_o  = p[DEPTH-1].flags;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 count_o <= '0;
    else if (flush_i)          count_o <= '0;
    else if (accept && !fire)  count_o <= count_o + CNT_W'(1);
    else if (fire && !accept)  count_o <= count_o - CNT_W'(1);
  end
endmodule

// File: tb/tb_complex_exec_pipe.sv
// Directed scoreboard bench for complex_exec_pipe (DEPTH=3).
module tb_complex_exec_pipe;
  import complex_exec_pipe_pkg::*;
  localparam int D = 3;
  localparam int CW = cnt_w(D);

  logic clk, reset, flush_i, valid_i, ready_o, valid_o, ready_i;
  logic [TAG_W-1:0]    tag_i, tag_o;
  logic [2*DATA_W-1:0] result_i, result_o;
  logic [FLAGS_W-1:0]  flags_i, flags_o;
  logic [CW-1:0]       count_o;

  complex_exec_pipe #(.DEPTH(D)) dut (
    .clk(clk), .reset(reset), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .tag_i(tag_i), .result_i(result_i), .flags_i(flags_i), .valid_o(valid_o),
    .ready_i(ready_i), .tag_o(tag_o), .result_o(result_o), .flags_o(flags_o),
    .count_o(count_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [TAG_W-1:0]    tag;
    logic [2*DATA_W-1:0] result;
    logic [FLAGS_W-1:0]  flags;
    int                  acyc;
  } exp_t;

  exp_t q[$];
  int total = 0, bad = 0, cyc = 0, mcount = 0, maxcnt = 0;
  bit chk_lat = 0;
  localparam logic [63:0] RBASE = 64'h0000_0001_FFFF_FFFE;

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
    end
  endtask

  // called in the negedge phase with inputs already applied
  task automatic tick();
    logic acc, fr, er;
    exp_t e;
    #1;
    er = !(mcount == D) || (ready_i && !flush_i);
    chk("ready_o", 64'(ready_o), 64'(er));
    acc = valid_i & ready_o & ~flush_i;
    fr  = valid_o & ready_i;
    if (fr) begin
      if (q.size() == 0) chk("spurious_fire", 64'(valid_o), 64'(0));
      else begin
        e = q.pop_front();
        chk("tag_o", 64'(tag_o), 64'(e.tag));
        chk("result_o", result_o, e.result);
        chk("flags_o", 64'(flags_o), 64'(e.flags));
        if (chk_lat) chk("latency", 64'(cyc - e.acyc), 64'(D));
      end
    end
    if (flush_i) begin
      q.delete();
      mcount = 0;
    end else begin
      if (acc) q.push_back('{tag: tag_i, result: result_i, flags: flags_i, acyc: cyc});
      mcount = mcount + int'(acc) - int'(fr);
    end
    @(posedge clk);
    cyc++;
    #1;
    chk("count_o", 64'(count_o), 64'(mcount));
    if (int'(count_o) > maxcnt) maxcnt = int'(count_o);
    @(negedge clk);
  endtask

  task automatic send(input int t, input logic [63:0] r, input logic [5:0] f);
    valid_i = 1'b1; tag_i = TAG_W'(t); result_i = r; flags_i = f;
    tick();
    valid_i = 1'b0;
  endtask

  task automatic drain();
    valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b1;
    for (int i = 0; i < 20 && q.size() != 0; i++) tick();
    chk("drained", 64'(q.size()), 64'(0));
    tick();
  endtask

  initial begin
    reset = 1'b1; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
    tag_i = '0; result_i = '0; flags_i = '0;
    #2;
    chk("rst_valid_o", 64'(valid_o), 64'(0));
    chk("rst_ready_o", 64'(ready_o), 64'(1));
    chk("rst_count_o", 64'(count_o), 64'(0));
    chk("rst_tag_o", 64'(tag_o), 64'(0));
    chk("rst_result_o", result_o, 64'(0));
    chk("rst_flags_o", 64'(flags_o), 64'(0));
    @(negedge clk);
    reset = 1'b0;

    // stream, zero-stall latency and throughput
    chk_lat = 1; ready_i = 1'b1; maxcnt = 0;
    for (int t = 1; t <= 4; t++) send(t, RBASE, 6'b010100);
    drain();
    chk("stream_peak", 64'(maxcnt), 64'(3));
    chk_lat = 0;

    // backpressure: only DEPTH accepted, ordered drain one per cycle
    ready_i = 1'b0;
    for (int t = 1; t <= 5; t++) send(t, RBASE + 64'(t), 6'(t));
    chk("bp_accepted", 64'(q.size()), 64'(3));
    chk("bp_ready_o", 64'(ready_o), 64'(0));
    ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_valid", 64'(valid_o), 64'(1));
      tick();
    end
    #1 chk("bp_empty_valid", 64'(valid_o), 64'(0));
    drain();

    // bubble collapse: 8 packs up behind stalled 7
    ready_i = 1'b0;
    send(7, 64'hDEAD_BEEF_0000_0007, 6'b000001);
    tick(); tick();
    send(8, 64'hCAFE_F00D_0000_0008, 6'b100001);
    tick();
    chk("bub_count", 64'(count_o), 64'(2));
    ready_i = 1'b1;
    #1 chk("bub_tag7", 64'(tag_o), 64'(7));
    tick();
    #1 chk("bub_valid8", 64'(valid_o), 64'(1));
    chk("bub_tag8", 64'(tag_o), 64'(8));
    drain();

    // full with simultaneous fire and accept
    ready_i = 1'b0;
    for (int t = 20; t < 23; t++) send(t, RBASE ^ 64'(t << 40), 6'(t));
    chk("full_count", 64'(count_o), 64'(3));
    ready_i = 1'b1;
    #1 chk("full_ready_fire", 64'(ready_o), 64'(1));
    send(23, 64'h1234_5678_9ABC_DEF0, 6'b111111);
    chk("full_count_hold", 64'(count_o), 64'(3));
    drain();

    // flush with input and fire pending
    ready_i = 1'b0;
    for (int t = 30; t < 33; t++) send(t, RBASE + 64'(t), 6'(t));
    flush_i = 1'b1; ready_i = 1'b1;
    valid_i = 1'b1; tag_i = 7'h55; result_i = 64'h5555_5555_5555_5555;
    #1 chk("flush_valid_o", 64'(valid_o), 64'(0));
    tick();
    flush_i = 1'b0; valid_i = 1'b0;
    chk("flush_count", 64'(count_o), 64'(0));
    for (int i = 0; i < 5; i++) begin
      #1 chk("flush_no_output", 64'(valid_o), 64'(0));
      tick();
    end

    // asynchronous reset mid-cycle
    ready_i = 1'b0;
    send(40, RBASE, 6'b000010);
    send(41, RBASE, 6'b000011);
    tick();
    chk("pre_rst_valid", 64'(valid_o), 64'(1));
    #2 reset = 1'b1;
    #1;
    chk("arst_valid_o", 64'(valid_o), 64'(0));
    chk("arst_count_o", 64'(count_o), 64'(0));
    chk("arst_ready_o", 64'(ready_o), 64'(1));
    #1 reset = 1'b0;
    q.delete(); mcount = 0;
    @(negedge clk);
    chk_lat = 1; ready_i = 1'b1;
    send(42, 64'hFEDC_BA98_7654_3210, 6'b101010);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/complex_exec_pipe.md
# complex_exec_pipe

Latency-matching pipeline between the complex ALU (multiply/divide/syscall) and the writeback/bypass stage. Each issued complex-ALU result and its destination tag are held for DEPTH cycles, emulating multi-cycle multiplier/divider latency. Results are then presented to writeback under a valid/ready handshake. Supports writeback backpressure with bubble collapsing, and a global flush on mispredict recovery.

## Interface
- DATA_W, 32, architectural data width; the result is 2*DATA_W wide (hi:lo).
- FLAGS_W, 6, execution-flag width, passed through unmodified.
- TAG_W, 7, destination physical-register / active-list tag width.
- DEPTH, 3, pipeline stages, ≥1; also the zero-stall latency.
- CNT_W, derived = clog2(DEPTH+1), occupancy count width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- flush_i  in  1  kills every in-flight entry and the current input.
- valid_i  in  1  upstream has a result to deliver.
- ready_o  out  1  pipe accepts this cycle.
- tag_i  in  TAG_W  destination tag.
- result_i  in  2*DATA_W  complex-ALU result.
- flags_i  in  FLAGS_W  complex-ALU flags.
- valid_o  out  1  head entry valid for writeback.
- ready_i  in  1  writeback consumes the head this cycle.
- tag_o  out  TAG_W  head tag.
- result_o  out  2*DATA_W  head result.
- flags_o  out  FLAGS_W  head flags.
- count_o  out  CNT_W  number of valid entries in the pipe.

## Operation
- Stages S0..S(DEPTH-1). Each stage holds {v, tag, result, flags}. S(DEPTH-1) is the head and drives the *_o ports.
- Handshakes:
  - Input accept = valid_i & ready_o & !flush_i.
  - Output fire = valid_o & ready_i.
- Advance rules:
  - Head advances (empties) when fire.
  - Stage k<DEPTH-1 moves into k+1 when S(k+1) is empty or advancing.
  - A stage that does not move holds. A stage that moves and receives nothing becomes empty.
- Bubble collapsing: an empty stage never blocks the stage behind it.
- ready_o = !S0.v | S0 advancing. This path is combinational from ready_i through the chain.
- valid_o = head.v & !flush_i.
- Flush:
  - All v bits clear at the next edge.
  - The input on the flush cycle is dropped.
  - Any fire coincident with flush is void.
- Payload registers load only on a move/accept. Contents of empty stages are don't-care.
- count_o: registered.
  - +1 on accept, −1 on fire, unchanged when both occur.
  - 0 after flush.
  - Range 0..DEPTH.
- No data transformation: result, flags and tag emerge bit-identical.

## Timing
- Reset values (async): all v=0, count_o=0, valid_o=0, ready_o=1. tag_o/result_o/flags_o are 0.
- Zero-stall latency: accept at edge N gives valid_o from cycle N+DEPTH. Throughput is one per cycle.
- Full: count_o=DEPTH and head stalled (ready_i=0) ⇒ ready_o=0. If ready_i=1 in the same cycle, ready_o=1 (simultaneous fire and accept).
- DEPTH=1: single register. ready_o = !v | ready_i.
- Reset mid-operation: all entries lost asynchronously. No output handshake completes during reset.
- Flush has priority over accept, fire and stall.

## Structure
- The shared package holds:
  - the stage payload struct {tag, result, flags};
  - the flag-field bit positions (Executed, Exception, Mispredict, etc.) used by writeback;
  - the CNT_W helper function.
- One sub-module is natural: complex_pipe_stage (one valid+payload register with an in/advance interface), instantiated DEPTH times in a generate loop. Top level holds the ready chain and the counter.

## Test plan
- Stream: DEPTH=3, ready_i=1, accept tags 1,2,3,4 on consecutive cycles (result_i=64'h0000_0001_FFFF_FFFE, flags=6'b010100) -> valid_o first in cycle 3 with tag 1, then tags 2,3,4 back-to-back, payload bit-identical, count_o peaks at 3.
- Backpressure: ready_i=0 while sending 5 entries -> exactly 3 accepted, ready_o=0, count_o=3. Release ready_i -> tags drain in order 1,2,3 one per cycle.
- Bubble collapse: accept tag 7, idle 2 cycles, accept tag 8 with ready_i=0 -> tag 8 sits directly behind tag 7 (count_o=2, ready_o=1). Raise ready_i -> tags 7 then 8 on consecutive cycles.
- Full with simultaneous fire/accept: count_o=3, ready_i=1, valid_i=1 -> ready_o=1, count_o stays 3.
- Flush: 3 in flight, assert flush_i with valid_i=1 and ready_i=1 -> valid_o=0 that cycle, count_o=0 next cycle, the flushed input never appears.
- Async reset: assert reset mid-cycle with 2 in flight -> valid_o and count_o go 0 without a clock edge. After deassertion, the first accepted entry appears after exactly DEPTH cycles.
